// File: rtl/latency_ctrl_pkg.sv
// latency_ctrl_pkg: shared helpers for the latency/credit controller slice.
//   clog2  - ceil(log2(v)), usable in constant expressions
//   cw_of  - width of a counter holding 0..depth (credit, FIFO fill)
//   aw_of  - width of a pointer indexing 0..depth-1 (at least 1 bit)
//   cr_op_e - credit counter operation selected each cycle
package latency_ctrl_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int cw_of(input int depth);
    return clog2(depth + 1);
  endfunction

  // A depth-1 FIFO still needs a 1-bit pointer to keep the vectors legal.
  function automatic int aw_of(input int depth);
    return (depth <= 1) ? 1 : clog2(depth);
  endfunction

  localparam int LAT_DEF   = 2;
  localparam int DSIZE_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CW_DEF    = cw_of(DEPTH_DEF);
  localparam int AW_DEF    = aw_of(DEPTH_DEF);

  typedef enum logic [1:0] {
    CR_HOLD = 2'd0,
    CR_DEC  = 2'd1,
    CR_INC  = 2'd2
  } cr_op_e;

endpackage

// File: rtl/latency_credit_ctrl_if.sv
// latency_credit_ctrl_if: bundles every handshake/bus signal of the controller.
//   producer side : in_valid, in_ready, in_data
//   datapath side : issue_valid, issue_data, res_valid, res_data
//   consumer side : out_valid, out_ready, out_data
//   status        : credit (free credits), ovf (sticky return overflow)
// modport slave  - the controller itself
// modport master - the surrounding environment (producer, datapath, consumer)
interface latency_credit_ctrl_if
  import latency_ctrl_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int CW = cw_of(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] in_data;
  logic             issue_valid;
  logic [DSIZE-1:0] issue_data;
  logic             res_valid;
  logic [DSIZE-1:0] res_data;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] out_data;
  logic [CW-1:0]    credit;
  logic             ovf;

  modport slave (
    input  in_valid, in_data, res_valid, res_data, out_ready,
    output in_ready, issue_valid, issue_data, out_valid, out_data, credit, ovf
  );

  modport master (
    output in_valid, in_data, res_valid, res_data, out_ready,
    input  in_ready, issue_valid, issue_data, out_valid, out_data, credit, ovf
  );
endinterface

// File: rtl/lcc_ret_fifo.sv
// lcc_ret_fifo: synchronous first-word-fall-through FIFO, DEPTH x DSIZE.
//   clk, rst        - clock, synchronous active-high reset (clears pointers)
//   wr_en, wr_data  - write request; dropped when full unless a read frees a slot
//   rd_en           - pop the head; ignored when empty
//   rd_data         - current head (valid whenever !empty)
//   empty, full     - occupancy flags
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module lcc_ret_fifo
  import latency_ctrl_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = aw_of(DEPTH);
  localparam int CW = cw_of(DEPTH);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_rd, do_wr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  // A same-cycle read frees the slot, so a full FIFO can still take a write.
  assign do_wr   = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/latency_credit_ctrl.sv
// latency_credit_ctrl: credit-based flow control in front of a fixed-latency,
// non-stallable datapath. An item is only issued when a return FIFO slot is
// reserved for it, so results LAT cycles later can always be captured.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - latency_credit_ctrl_if.slave: producer handshake, datapath
//               issue/result, consumer handshake, credit count, ovf flag
//   lat_err   - (LATENCY_CREDIT_CTRL_CHECK_EN only) sticky: a result arrived
//               on a cycle that does not match an issue LAT cycles earlier
// Optional feature macro: LATENCY_CREDIT_CTRL_CHECK_EN.
module latency_credit_ctrl
  import latency_ctrl_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int DSIZE = DSIZE_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  latency_credit_ctrl_if.slave bus
`ifdef LATENCY_CREDIT_CTRL_CHECK_EN
  ,
  output logic lat_err
`endif
);
  localparam int CW = cw_of(DEPTH);

  logic [CW-1:0] credit_q, credit_d;
  logic          ovf_q;
  cr_op_e        cr_op;
  logic          accept, pop, res_wr;
  logic          fifo_empty, fifo_full;

  // in_ready depends only on the registered credit, never on out_ready.
  assign bus.in_ready    = (credit_q != '0) && !rst;
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.issue_valid = accept;
  assign bus.issue_data  = bus.in_data;

  assign bus.out_valid   = !fifo_empty;
  assign pop             = bus.out_valid && bus.out_ready;
  assign res_wr          = bus.res_valid && !rst;

  assign bus.credit      = credit_q;
  assign bus.ovf         = ovf_q;

  lcc_ret_fifo #(
    .DSIZE (DSIZE),
    .DEPTH (DEPTH)
  ) u_ret_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (res_wr),
    .wr_data (bus.res_data),
    .rd_en   (pop),
    .rd_data (bus.out_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Accept and pop in the same cycle cancel; saturation guards keep the
  // counter inside 0..DEPTH even if a misbehaving datapath over-fills.
  always_comb begin
    cr_op = CR_HOLD;
    if (accept && !pop)      cr_op = CR_DEC;
    else if (pop && !accept) cr_op = CR_INC;

    credit_d = credit_q;
    case (cr_op)
      CR_DEC:  if (credit_q != '0)           credit_d = credit_q - CW'(1);
      CR_INC:  if (credit_q != CW'(DEPTH))   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CW'(DEPTH);
      ovf_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      // The FIFO itself drops the word; here we only remember it happened.
      if (res_wr && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

`ifdef LATENCY_CREDIT_CTRL_CHECK_EN
  logic exp_v;
  logic lat_err_q;

  if (LAT == 0) begin : g_exp_lat0
    assign exp_v = accept;
  end else begin : g_exp_shift
    // Delay line of issue pulses: bit LAT-1 is the issue from LAT cycles ago.
    logic [LAT-1:0] exp_q;
    always_ff @(posedge clk) begin
      if (rst) exp_q <= '0;
      else     exp_q <= (exp_q << 1) | LAT'(accept);
    end
    assign exp_v = exp_q[LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst)                        lat_err_q <= 1'b0;
    else if (bus.res_valid != exp_v) lat_err_q <= 1'b1;
  end

  assign lat_err = lat_err_q;
`endif

endmodule

// File: doc/latency_credit_ctrl.md
Name: latency_credit_ctrl

Overview:
- Credit-based flow controller for an external fixed-latency, non-stallable datapath, e.g. a chain of `latency` stages.
- Accepts valid/ready input, issues items into the datapath only when a return slot is guaranteed, and captures results into an internal return FIFO.
- Presents the results downstream with valid/ready.
- Sits between a handshaked producer and any LAT-cycle pipe that cannot absorb backpressure.

Parameters:
- LAT, 2, datapath latency in cycles (>=0); issue at cycle t returns res_valid at t+LAT.
- DSIZE, 8, data width, applies to both issued and returned data.
- DEPTH, 4, return FIFO depth and initial credit count (>=1); full throughput requires DEPTH >= LAT+2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream item valid.
- in_ready  out  1  upstream ready.
- in_data  in  DSIZE  upstream payload.
- issue_valid  out  1  one-cycle pulse into the datapath input.
- issue_data  out  DSIZE  payload into the datapath.
- res_valid  in  1  datapath result valid.
- res_data  in  DSIZE  datapath result.
- out_valid  out  1  downstream valid.
- out_ready  in  1  downstream ready.
- out_data  out  DSIZE  downstream payload (FIFO head).
- credit  out  $clog2(DEPTH+1)  free credits.
- ovf  out  1  sticky: result arrived while FIFO full.

Behaviour:
- Reset values:
  - credit = DEPTH.
  - FIFO empty, out_valid = 0, ovf = 0.
  - in_ready = 0 while rst is high.
- in_ready = (credit != 0) && !rst. Combinational from the registered credit only; no combinational path from out_ready.
- Accept = in_valid && in_ready.
  - issue_valid = accept; issue_data = in_data (combinational pass-through).
- Pop = out_valid && out_ready.
- Credit update, one register:
  - accept only: credit-1.
  - pop only: credit+1.
  - both in the same cycle: unchanged.
  - Never exceeds DEPTH; never goes below 0.
- Credit freed by a pop is visible on in_ready the next cycle. At credit = 0, a simultaneous pop does not raise in_ready in that same cycle.
- Return FIFO:
  - Synchronous, DEPTH entries, registered write on res_valid.
  - First-word-fall-through read: out_valid = !empty, out_data = head.
  - Write and read in the same cycle are both allowed, including when full (pop frees the slot).
  - Pointer wrap is modulo DEPTH; DEPTH need not be a power of two.
- Latency: with the FIFO empty and out_ready = 1, an item accepted at cycle t appears at out_valid at cycle t+LAT+1. Throughput is 1 item/cycle when DEPTH >= LAT+2.
- res_valid while the FIFO is full with no pop in the same cycle: data dropped, ovf set and held until rst. This indicates a datapath violating LAT or sharing the controller.
- LAT = 0: res_valid arrives in the issue cycle; behaviour is otherwise identical.
- Reset mid-operation: FIFO and credits are cleared immediately. The datapath must share rst so no pre-reset results return. Any res_valid while rst is high is ignored.
- Order is strictly preserved end to end.

Optional Feature:
- Macro: LATENCY_CREDIT_CTRL_CHECK_EN.
- Defined:
  - Adds an internal LAT-deep expected-valid shift register, shifted by issue_valid and cleared by rst.
  - Adds output port lat_err (1 bit, reset 0).
  - lat_err is set sticky when res_valid != expected[LAT-1]. For LAT = 0 the comparison is res_valid != issue_valid.
- Undefined: no shift register, no lat_err port; res_valid is trusted.

Decomposition:
- Shared package latency_ctrl_pkg:
  - function clog2.
  - localparam helpers CW = clog2(DEPTH+1) and AW = clog2(DEPTH).
- One natural sub-module: lcc_ret_fifo.
  - Synchronous FWFT FIFO, DEPTH x DSIZE.
  - Ports: wr_en, wr_data, rd_en, rd_data, empty, full, sync rst.
  - Reusable elsewhere.
- Credit counter, ovf, and the check logic stay in the top level.

Test Plan:
- Reset: assert rst 3 cycles, release → in_ready = 1, credit = 4, out_valid = 0, ovf = 0 (LAT=2, DEPTH=4).
- Burst with out_ready = 0, datapath model LAT=2:
  - Stimulus: in_valid held with data 0x11..0x16.
  - Required: exactly 0x11..0x14 accepted; in_ready = 0 after the 4th accept; credit = 0.
  - Required: out_valid rises 3 cycles after the first issue; out_data = 0x11.
- Streaming, out_ready = 1, 20 sequential items:
  - Required: 1 item/cycle sustained with DEPTH = 4.
  - Required: each item out exactly 3 cycles after its issue, in order.
- Simultaneous pop and accept at credit = 1 → credit stays 1. Pop at credit = 0 → in_ready = 0 that cycle, 1 the next.
- Overflow: FIFO full, out_ready = 0, inject an extra res_valid with 0xEE → ovf = 1 and stays set; FIFO contents unchanged; 0xEE never emitted.
- With CHECK_EN: model returns the issue at t+1 instead of t+2 → lat_err = 1 (sticky). Correct LAT stream over 50 items → lat_err stays 0.
